// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single data-memory port between the CPU core and the FPGA I/O
// front end. Each master runs a req/ack handshake. The arbiter grants one
// master at a time, forwards the latched request to memory, and returns the
// memory response, or ERR_DATA if the watchdog aborts the transfer, with a
// one-cycle ack.
//
// Priority follows cpu_enable (1: CPU first, 0: I/O first). A starvation
// guard forces the repeatedly losing master to win once it has lost
// STARVE_LIMIT consecutive contended grants.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cpu_enable               priority select, sampled only when idle
//   cpu_req/we/addr/wdata    CPU request side
//   cpu_rdata, cpu_ack       CPU response side (ack is a 1-cycle pulse)
//   io_req/we/addr/wdata     I/O request side
//   io_rdata, io_ack         I/O response side (ack is a 1-cycle pulse)
//   mem_req/we/addr/wdata    memory request, held until mem_ack or abort
//   mem_rdata, mem_ack       memory response
//   timeout_err              1-cycle pulse alongside the ack of an aborted transfer
//   owner                    current/last grant: 0 = CPU, 1 = I/O
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                STARVE_LIMIT = 4,
    parameter int                TIMEOUT      = 16,
    parameter logic [DATA_W-1:0] ERR_DATA     = DATA_W'(32'hBAD0_BAD0)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_enable,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              timeout_err,
    output logic              owner
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WW-1:0]     wdog_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              cpu_ack_reg;
    logic              io_ack_reg;
    logic [DATA_W-1:0] cpu_rdata_reg;
    logic [DATA_W-1:0] io_rdata_reg;
    logic              timeout_err_reg;
    logic              owner_reg;

    // Master-indexed views of the request side: index 0 = CPU, 1 = I/O.
    logic [1:0]             req_vec;
    logic [1:0]             we_vec;
    logic [1:0][ADDR_W-1:0] addr_vec;
    logic [1:0][DATA_W-1:0] wdata_vec;
    logic [1:0]             at_limit;

    logic              arb_fire;
    logic              grant_sel;
    logic              xfer_end;
    logic [DATA_W-1:0] xfer_data;

    assign req_vec   = {io_req, cpu_req};
    assign we_vec    = {io_we, cpu_we};
    assign addr_vec  = {io_addr, cpu_addr};
    assign wdata_vec = {io_wdata, cpu_wdata};
    assign arb_fire  = (state_reg == IDLE) && (|req_vec);

    // Per-master consecutive-loss counters. Only a contended grant lets the
    // loser's count grow; any uncontended grant clears both.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_starve
            logic [SW-1:0] cnt_reg;
            logic [SW-1:0] cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (arb_fire) begin
                    if (req_vec != 2'b11 || grant_sel == 1'(gi))
                        cnt_next = '0;
                    else if (cnt_reg != STARVE_MAX)
                        cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst)
                    cnt_reg <= '0;
                else
                    cnt_reg <= cnt_next;
            end

            assign at_limit[gi] = (cnt_reg == STARVE_MAX);
        end
    endgenerate

    // Winner select. Only the loser of the previous contended grant can hold
    // a nonzero count, so both limits are never reached together.
    always_comb begin
        grant_sel = 1'b0;
        case (req_vec)
            2'b10: grant_sel = 1'b1;
            2'b11: begin
                if (at_limit[1])
                    grant_sel = 1'b1;
                else if (at_limit[0])
                    grant_sel = 1'b0;
                else
                    grant_sel = ~cpu_enable;
            end
            default: grant_sel = 1'b0;
        endcase
    end

    // A mem_ack in the final watchdog cycle wins over the abort.
    assign xfer_end  = mem_ack || (wdog_reg == WDOG_LAST);
    assign xfer_data = mem_ack ? mem_rdata : ERR_DATA;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            wdog_reg        <= '0;
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            cpu_ack_reg     <= 1'b0;
            io_ack_reg      <= 1'b0;
            cpu_rdata_reg   <= '0;
            io_rdata_reg    <= '0;
            timeout_err_reg <= 1'b0;
            owner_reg       <= 1'b0;
        end else begin
            cpu_ack_reg     <= 1'b0;
            io_ack_reg      <= 1'b0;
            timeout_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (arb_fire) begin
                        state_reg     <= XFER;
                        wdog_reg      <= '0;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= we_vec[grant_sel];
                        mem_addr_reg  <= addr_vec[grant_sel];
                        mem_wdata_reg <= wdata_vec[grant_sel];
                        owner_reg     <= grant_sel;
                    end
                end
                XFER: begin
                    if (xfer_end) begin
                        state_reg       <= DONE;
                        mem_req_reg     <= 1'b0;
                        timeout_err_reg <= ~mem_ack;
                        if (owner_reg) begin
                            io_ack_reg   <= 1'b1;
                            io_rdata_reg <= xfer_data;
                        end else begin
                            cpu_ack_reg   <= 1'b1;
                            cpu_rdata_reg <= xfer_data;
                        end
                    end else begin
                        wdog_reg <= wdog_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_reg;
    assign mem_we      = mem_we_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign cpu_ack     = cpu_ack_reg;
    assign io_ack      = io_ack_reg;
    assign cpu_rdata   = cpu_rdata_reg;
    assign io_rdata    = io_rdata_reg;
    assign timeout_err = timeout_err_reg;
    assign owner       = owner_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed steps followed by a randomized phase. A small memory slave and a
// transaction-level reference (winner choice from the loss streaks, response
// data from a 16-word memory image, timeout when the memory never answers)
// predict every grant and every ack.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int          SL  = 2;
    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hBAD0_BAD0;

    logic        clk;
    logic        rst;
    logic        cpu_enable;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ack;
    logic        io_req, io_we;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic        io_ack;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        timeout_err;
    logic        owner;

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL), .TIMEOUT(TO), .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .rst(rst), .cpu_enable(cpu_enable),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .timeout_err(timeout_err), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          xn    = 0;
    int          cpu_streak, io_streak;   // consecutive contended losses
    logic [31:0] mem_model [16];
    logic        last_owner;
    logic [7:0]  grant_hist;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_req = 1'b0;
        io_req = 1'b0;
        mem_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        cpu_streak = 0;
        io_streak = 0;
        last_owner = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_io_ack", io_ack, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_io_rdata", io_rdata, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_owner", owner, 0);
    endtask

    // One arbitration + transfer, starting in an IDLE cycle with the requests
    // already on the inputs. wt = XFER cycle index at which memory acks
    // (>= TO means never). hold keeps the winner's req high afterwards.
    task automatic xact(input int wt, input bit hold, input bit jitter);
        bit          c, i, w, ewe, timed, acked;
        logic [31:0] ea, ed, exp_rd;
        int          n, exp_n;
        c = cpu_req;
        i = io_req;
        if (c && i) begin
            if (io_streak >= SL)       w = 1'b1;
            else if (cpu_streak >= SL) w = 1'b0;
            else                       w = !cpu_enable;
            if (w) begin
                io_streak = 0;
                cpu_streak = (cpu_streak < SL) ? cpu_streak + 1 : SL;
            end else begin
                cpu_streak = 0;
                io_streak = (io_streak < SL) ? io_streak + 1 : SL;
            end
        end else begin
            w = i;
            cpu_streak = 0;
            io_streak = 0;
        end
        ea     = w ? io_addr : cpu_addr;
        ed     = w ? io_wdata : cpu_wdata;
        ewe    = w ? io_we : cpu_we;
        exp_rd = mem_model[ea[3:0]];
        timed  = (wt >= TO);
        exp_n  = timed ? TO : wt + 1;

        tick();
        chk("grant_owner", owner, w);
        chk("grant_we", mem_we, ewe);
        chk("grant_wdata", mem_wdata, ed);

        n = 0;
        acked = 1'b0;
        for (int k = 0; k < TO; k++) begin
            if (jitter) cpu_enable = 1'($urandom_range(0, 1));
            chk("xfer_mem_req", mem_req, 1);
            chk("xfer_addr", mem_addr, ea);
            chk("xfer_no_ack", {cpu_ack, io_ack}, 0);
            n++;
            if (k == wt) begin
                mem_ack = 1'b1;
                mem_rdata = ewe ? $urandom : mem_model[mem_addr[3:0]];
                if (mem_we) mem_model[mem_addr[3:0]] = mem_wdata;
                acked = 1'b1;
            end else begin
                mem_rdata = $urandom;
            end
            tick();
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (acked || !mem_req) break;
        end

        chk("xfer_cycles", n, exp_n);
        chk("done_mem_req", mem_req, 0);
        chk("done_owner_ack", w ? io_ack : cpu_ack, 1);
        chk("done_other_ack", w ? cpu_ack : io_ack, 0);
        chk("done_timeout_err", timeout_err, timed);
        if (timed)
            chk("done_err_data", w ? io_rdata : cpu_rdata, ERR);
        else if (!ewe)
            chk("done_rdata", w ? io_rdata : cpu_rdata, exp_rd);
        chk("done_owner", owner, w);

        $display("xact %0d: owner=%s we=%0d addr=%0h wait=%0d timeout=%0d",
                 xn, w ? "io" : "cpu", ewe, ea, wt, timed);
        xn++;
        last_owner = w;
        grant_hist = {grant_hist[6:0], w};

        if (!hold) begin
            if (w) io_req = 1'b0;
            else   cpu_req = 1'b0;
        end
        tick();
        chk("idle_acks", {cpu_ack, io_ack, timeout_err}, 0);
        chk("idle_mem_req", mem_req, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int wt, r;
        rst = 1'b1; cpu_enable = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        io_req = 1'b0; io_we = 1'b0; io_addr = '0; io_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        grant_hist = '0;
        for (int k = 0; k < 16; k++) mem_model[k] = $urandom;

        do_reset();
        chk_reset_state();

        // CPU read, memory answers two cycles after mem_req rises.
        mem_model[0] = 32'h2A;
        cpu_enable = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h140;
        xact(2, 0, 0);
        chk("t1_cpu_rdata", cpu_rdata, 32'h2A);

        // Simultaneous I/O write and CPU read with I/O priority.
        cpu_enable = 1'b0;
        io_req = 1'b1; io_we = 1'b1; io_addr = 32'd220; io_wdata = 32'h12;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd220;
        xact(1, 0, 0);
        xact(1, 0, 0);
        chk("t2_order", grant_hist[1:0], 2'b10);
        chk("t2_readback", cpu_rdata, 32'h12);

        // Starvation guard: CPU keeps requesting, I/O held.
        do_reset();
        chk_reset_state();
        cpu_enable = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd3;
        io_req = 1'b1; io_we = 1'b0; io_addr = 32'd7;
        xact(0, 1, 0);
        xact(0, 1, 0);
        xact(0, 0, 0);
        chk("t3_order", grant_hist[2:0], 3'b001);
        xact(0, 0, 0);

        // Watchdog: never, exactly at the boundary, and ack in the abort cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd9;
        xact(TO + 5, 0, 0);
        io_req = 1'b1; io_we = 1'b1; io_addr = 32'd4; io_wdata = 32'hCAFE_0004;
        xact(TO, 0, 0);
        io_req = 1'b1; io_we = 1'b0; io_addr = 32'd5;
        xact(TO - 1, 0, 0);

        // Zero-wait memory: ack two edges after the request is sampled.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd6; cpu_wdata = 32'h0000_6666;
        xact(0, 0, 0);

        // Reset in the second XFER cycle of an I/O transfer.
        io_req = 1'b1; io_we = 1'b0; io_addr = 32'd11;
        tick();
        chk("t5_grant_req", mem_req, 1);
        chk("t5_grant_owner", owner, 1);
        tick();
        chk("t5_xfer2_req", mem_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        io_req = 1'b0;
        cpu_streak = 0;
        io_streak = 0;
        last_owner = 1'b0;
        chk_reset_state();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t5_no_ack", {cpu_ack, io_ack, mem_req}, 0);
        end

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            cpu_enable = 1'($urandom_range(0, 1));
            if (!cpu_req && $urandom_range(0, 2) != 0) begin
                cpu_req = 1'b1;
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 32'($urandom_range(0, 15));
                cpu_wdata = $urandom;
            end
            if (!io_req && $urandom_range(0, 2) != 0) begin
                io_req = 1'b1;
                io_we = 1'($urandom_range(0, 1));
                io_addr = 32'($urandom_range(0, 15));
                io_wdata = $urandom;
            end
            if (cpu_req || io_req) begin
                r = $urandom_range(0, 9);
                wt = (r == 0) ? TO + 3 : (r == 1) ? TO - 1 : $urandom_range(0, 4);
                xact(wt, 0, 1);
            end else begin
                tick();
                chk("rand_idle_req", mem_req, 0);
                chk("rand_idle_owner", owner, last_owner);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
